// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the multi-bit shift sequencer.
// State encodings, direction encodings and the fixed data width.
package shift_seq_pkg;

  localparam int DATA_W = 8;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Single-step 8-bit logical shifter, zero fill.
// lr=0 shifts left by one, lr=1 shifts right by one.
module shift_sequencer_shifter
  import shift_seq_pkg::*;
(
  input  logic [DATA_W-1:0] x_i,
  input  logic              lr_i,
  output logic [DATA_W-1:0] z_o
);

  // One-bit shift in the requested direction
  always_comb begin
    z_o = x_i;
    unique case (lr_i)
      DIR_LEFT:  z_o = {x_i[DATA_W-2:0], 1'b0};
      DIR_RIGHT: z_o = {1'b0, x_i[DATA_W-1:1]};
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-bit shift controller: iterates a one-bit shifter once per clock.
// Request in over valid/ready, result out over valid/ready.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int AMT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_dir,
  input  logic [AMT_W-1:0]  in_amt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  state_t             state_q;
  logic [DATA_W-1:0]  data_q;
  logic               dir_q;
  logic [AMT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  data_d;

  shift_sequencer_shifter u_shifter (
    .x_i  (data_q),
    .lr_i (dir_q),
    .z_o  (data_d)
  );

  // Sequencer FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      dir_q   <= DIR_LEFT;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            dir_q  <= in_dir;
            cnt_q  <= in_amt;
            if (in_amt == '0) state_q <= S_DONE;
            else              state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          data_q <= data_d;
          if (cnt_q != '0) cnt_q <= cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) state_q <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer.
// Each task drives one scenario and checks its own results inline.
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_dir;
  logic [2:0] in_amt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int n_chk;
  int n_fail;

  shift_sequencer #(.AMT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request from a negedge; accept edge is the next posedge
  task automatic send(input logic [7:0] d, input logic dr,
                      input logic [2:0] a);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dr;
    in_amt   = a;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'hxx;
  endtask

  // Count edges after the accept edge until out_valid; -1 on timeout
  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!out_valid) edges = -1;
  endtask

  // One-edge output handshake
  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    n_chk++;
    if (out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_out_data got %h want 00", out_data);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single(input string nm, input logic [7:0] d,
                             input logic dr, input logic [2:0] a,
                             input logic [7:0] exp);
    int e;
    send(d, dr, a);
    wait_valid(e);
    n_chk++;
    if (e !== int'(a)) begin
      n_fail++;
      $display("FAIL %s_latency got %0d want %0d", nm, e, a);
    end
    n_chk++;
    if (out_data !== exp) begin
      n_fail++;
      $display("FAIL %s_data got %h want %h", nm, out_data, exp);
    end
    n_chk++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_flags got busy=%b in_ready=%b want 1 0",
               nm, busy, in_ready);
    end
    consume();
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_release got ov=%b ir=%b want 0 1",
               nm, out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    int e;
    send(8'h4B, DIR_LEFT, 3'd2);
    wait_valid(e);
    n_chk++;
    if (e !== 2 || out_data !== 8'h2C) begin
      n_fail++;
      $display("FAIL bp_first got lat=%0d data=%h want 2 2c", e, out_data);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h81;
    in_dir   = DIR_RIGHT;
    in_amt   = 3'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (out_valid !== 1'b1 || out_data !== 8'h2C || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d got ov=%b data=%h ir=%b want 1 2c 0",
                 i, out_valid, out_data, in_ready);
      end
      if (i == 2) in_data = 8'h55;
    end
    in_data = 8'h81;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_chk++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_b2b got ir=%b busy=%b ov=%b want 1 0 0",
               in_ready, busy, out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_chk++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_second_accept got busy=%b ir=%b want 1 0",
               busy, in_ready);
    end
    wait_valid(e);
    n_chk++;
    if (e !== 2 || out_data !== 8'h20) begin
      n_fail++;
      $display("FAIL bp_second got lat=%0d data=%h want 2 20", e, out_data);
    end
    consume();
  endtask

  task automatic test_reset_midop();
    int e;
    send(8'hFF, DIR_LEFT, 3'd7);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL midop_shift%0d got ov=%b busy=%b want 0 1",
                 i, out_valid, busy);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00
        || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset got busy=%b ir=%b data=%h ov=%b want 0 1 00 0",
               busy, in_ready, out_data, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midop_idle%0d got ov=%b busy=%b want 0 0",
                 i, out_valid, busy);
      end
    end
    send(8'h01, DIR_LEFT, 3'd2);
    wait_valid(e);
    n_chk++;
    if (e !== 2 || out_data !== 8'h04) begin
      n_fail++;
      $display("FAIL midop_next got lat=%0d data=%h want 2 04", e, out_data);
    end
    consume();
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_dir    = DIR_LEFT;
    in_amt    = 3'd0;
    out_ready = 1'b0;
    test_reset();
    test_single("left1",  8'b01001011, DIR_LEFT,  3'd1, 8'b10010110);
    test_single("right3", 8'b01001011, DIR_RIGHT, 3'd3, 8'b00001001);
    test_single("amt0",   8'h4B,       DIR_RIGHT, 3'd0, 8'h4B);
    test_single("left7",  8'hFF,       DIR_LEFT,  3'd7, 8'h80);
    test_single("right7", 8'hFF,       DIR_RIGHT, 3'd7, 8'h01);
    test_backpressure();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
